// File: rtl/oh_pads_cfgchain.sv
// oh_pads_cfgchain: loads a full pad-ring configuration word and shifts it
// MSB first onto a serial chain (chain_clk/chain_data), then pulses
// chain_load so the pads latch the new settings.
//
// Handshake: a request is accepted on a rising clk edge where
// cfg_valid=1 and cfg_ready=1. cfg_ready is high only in IDLE.
// cfg_data and clkdiv are captured at that edge only, so later changes
// to them cannot disturb a transfer in progress.
module oh_pads_cfgchain #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N*CW-1:0]  cfg_data,
    input  logic [3:0]       clkdiv,
    output logic             chain_clk,
    output logic             chain_data,
    output logic             chain_load,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int W  = N * CW;
    localparam int BW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    sr;        // bits still to be sent, next one at the top
    logic [3:0]      div_q;     // phase length minus one, frozen at accept
    logic [3:0]      ph;        // cycles spent in the current phase
    logic [BW-1:0]   bitcnt;    // index of the bit currently on chain_data
    logic            accept;
    logic            ph_end;
    logic            last_bit;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign accept    = cfg_valid & cfg_ready;
    assign ph_end    = (ph == div_q);
    assign last_bit  = (bitcnt == BW'(W - 1));

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: SHIFT ends at the close of the last bit's high phase,
    // LOAD ends after one phase length.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (ph_end && chain_clk && last_bit) state_nxt = LOAD;
            LOAD:    if (ph_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: chain outputs are flops so the pad ring never sees glitches.
    // chain_clk toggles at every phase end; a new bit is launched only when
    // the high phase ends, so chain_data is stable across the whole bit.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sr         <= '0;
            div_q      <= '0;
            ph         <= '0;
            bitcnt     <= '0;
            chain_clk  <= 1'b0;
            chain_data <= 1'b0;
            chain_load <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        chain_data <= cfg_data[W-1];
                        sr         <= {cfg_data[W-2:0], 1'b0};
                        div_q      <= clkdiv;
                        ph         <= '0;
                        bitcnt     <= '0;
                        chain_clk  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ph_end) begin
                        ph <= '0;
                        if (!chain_clk) begin
                            chain_clk <= 1'b1;
                        end else begin
                            chain_clk <= 1'b0;
                            if (last_bit) begin
                                chain_data <= 1'b0;
                                chain_load <= 1'b1;
                            end else begin
                                bitcnt     <= bitcnt + 1'b1;
                                chain_data <= sr[W-1];
                                sr         <= {sr[W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                LOAD: begin
                    if (ph_end) begin
                        ph         <= '0;
                        chain_load <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                default: begin
                    chain_load <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oh_pads_cfgchain.sv
// Testbench for oh_pads_cfgchain: every cycle of a transfer is compared
// against a cycle-by-cycle trace built from the serial protocol rules.
module tb_oh_pads_cfgchain;

    localparam int N  = 8;
    localparam int CW = 8;
    localparam int W  = N * CW;

    // observed vector layout: {cfg_ready, busy, chain_clk, chain_data, chain_load, done}
    localparam logic [5:0] IDLE_VEC = 6'b100000;

    logic          clk = 1'b0;
    logic          nreset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [W-1:0]  cfg_data = '0;
    logic [3:0]    clkdiv = '0;
    logic          cfg_ready;
    logic          chain_clk;
    logic          chain_data;
    logic          chain_load;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] exp_q[$];

    oh_pads_cfgchain #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .clkdiv     (clkdiv),
        .chain_clk  (chain_clk),
        .chain_data (chain_data),
        .chain_load (chain_load),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [5:0] obs_vec();
        return {cfg_ready, busy, chain_clk, chain_data, chain_load, done};
    endfunction

    // Reference trace: each bit MSB first spends d+1 cycles low then d+1
    // high, then d+1 load cycles, then a single done cycle back in idle.
    task automatic build_model(input logic [63:0] data, input int d);
        logic bit_v;
        logic hi;
        exp_q.delete();
        for (int b = W - 1; b >= 0; b--) begin
            bit_v = data[b];
            for (int c = 0; c < 2 * (d + 1); c++) begin
                hi = (c >= d + 1);
                exp_q.push_back({1'b0, 1'b1, hi, bit_v, 1'b0, 1'b0});
            end
        end
        for (int c = 0; c < d + 1; c++) exp_q.push_back(6'b010010);
        exp_q.push_back(6'b100001);
    endtask

    task automatic do_idle(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check(tag, obs_vec(), IDLE_VEC);
        end
    endtask

    // Called at a negedge with the DUT idle or in its done cycle.
    // mode 0: noisy inputs (random cfg_valid/cfg_data/clkdiv) during transfer
    // mode 1: cfg_valid held high so the next transfer follows back-to-back
    // mode 2: reset pulled in the middle of bit 20
    // mode 3: clkdiv switched to 7 right after accept
    task automatic do_xfer(input logic [63:0] data, input logic [3:0] d,
                           input int mode, input string tag);
        int k;
        logic [5:0] e;
        cfg_valid = 1'b1;
        cfg_data  = data;
        clkdiv    = d;
        build_model(data, int'(d));
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check(tag, obs_vec(), e);
            if (mode == 2 && k == 20 * 2 * (int'(d) + 1) + 1) begin
                nreset = 1'b0;
                #1;
                check({tag, "_async"}, obs_vec(), IDLE_VEC);
                @(negedge clk);
                check({tag, "_held"}, obs_vec(), IDLE_VEC);
                cfg_valid = 1'b0;
                nreset    = 1'b1;
                exp_q.delete();
                break;
            end else if (exp_q.size() == 0) begin
                cfg_valid = (mode == 1);
            end else if (mode == 1) begin
                cfg_valid = 1'b1;
                cfg_data  = {$urandom, $urandom};
                clkdiv    = 4'($urandom_range(0, 15));
            end else if (mode == 3) begin
                cfg_valid = 1'b0;
                clkdiv    = 4'd7;
            end else begin
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_data  = {$urandom, $urandom};
                clkdiv    = 4'($urandom_range(0, 15));
            end
            k++;
        end
    endtask

    initial begin
        // reset: outputs must settle without any clk edge
        #2 nreset = 1'b0;
        #1 check("reset_async", obs_vec(), IDLE_VEC);
        @(negedge clk);
        check("reset_held", obs_vec(), IDLE_VEC);
        nreset = 1'b1;
        do_idle(2, "idle_after_reset");

        do_xfer(64'hA5, 4'd0, 0, "a5_div0");
        do_idle(2, "idle_a5");

        do_xfer({$urandom, $urandom}, 4'd3, 0, "div3");
        do_idle(1, "idle_div3");

        do_xfer({$urandom, $urandom}, 4'd2, 1, "b2b_first");
        do_xfer({$urandom, $urandom}, 4'd5, 0, "b2b_second");
        do_idle(1, "idle_b2b");

        do_xfer({$urandom, $urandom}, 4'd1, 2, "rst_mid");
        do_idle(3, "idle_after_abort");
        do_xfer({$urandom, $urandom}, 4'd1, 0, "after_rst");
        do_idle(1, "idle_after_rst");

        do_xfer({$urandom, $urandom}, 4'd0, 3, "div_change");
        do_idle(1, "idle_div_change");

        do_xfer(64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 0, "div15");
        do_idle(1, "idle_div15");

        for (int i = 0; i < 6; i++) begin
            do_xfer({$urandom, $urandom}, 4'($urandom_range(0, 6)),
                    int'($urandom_range(0, 1)), "random");
        end
        cfg_valid = 1'b0;
        do_idle(2, "idle_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/oh_pads_cfgchain.md
OH_PADS_CFGCHAIN -- requirements
Module: oh_pads_cfgchain

Interface
REQ-001 Parameter N, default 8: number of pads on the configuration chain.
REQ-002 Parameter CW, default 8: configuration bits per pad.
REQ-003 clk  input  1  the single block clock; all state updates on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-005 cfg_valid  input  1  request to load a new pad-ring configuration.
REQ-006 cfg_ready  output  1  block can accept a request this cycle.
REQ-007 cfg_data  input  N*CW  full ring configuration; pad p occupies bits [p*CW+CW-1 : p*CW].
REQ-008 clkdiv  input  4  chain clock phase length minus one, in clk cycles.
REQ-009 chain_clk  output  1  serial clock to the pad-ring configuration chain.
REQ-010 chain_data  output  1  serial data to the chain, launched while chain_clk is low.
REQ-011 chain_load  output  1  latch strobe that transfers the chain contents into the pad config latches.
REQ-012 busy  output  1  transfer in progress (state not IDLE).
REQ-013 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-014 The state machine SHALL have the states IDLE, SHIFT and LOAD.
REQ-015 cfg_ready SHALL be 1 exactly when the state is IDLE.
REQ-016 Accept SHALL occur on any rising edge where cfg_valid=1 and cfg_ready=1; on accept, latch cfg_data into the shift register and clkdiv into the divider register, then go to SHIFT.
REQ-017 cfg_valid while busy SHALL be ignored, with no effect on the transfer in progress.
REQ-018 The block SHALL shift MSB first: bit N*CW-1 first and bit 0 last.
REQ-019 Each bit SHALL occupy a low phase then a high phase of chain_clk, each lasting clkdiv+1 clk cycles; chain_data SHALL be stable for the whole bit.
REQ-020 In the first cycle after accept, chain_data SHALL equal bit N*CW-1 and chain_clk SHALL be 0.
REQ-021 The SHIFT state SHALL last exactly 2*(clkdiv+1)*N*CW cycles, counted with a bit counter of width clog2(N*CW+1) and a 4-bit phase counter.
REQ-022 After the high phase of the last bit, go to LOAD: chain_clk=0, chain_data=0, chain_load=1 for clkdiv+1 cycles.
REQ-023 After LOAD, return to IDLE; done=1 for exactly the first IDLE cycle.
REQ-024 A new accept SHALL be allowed in the same cycle as done=1.
REQ-025 clkdiv=15 SHALL give phases of 16 cycles; there SHALL be no wrap or overflow of the phase counter.
REQ-026 Changes to clkdiv or cfg_data after accept SHALL NOT affect the transfer in progress.
REQ-027 chain_clk, chain_data and chain_load SHALL be driven directly from flops (glitch-free).
REQ-028 busy SHALL be 1 in SHIFT and LOAD, and 0 in IDLE.

Reset
REQ-029 While nreset=0: state=IDLE, chain_clk=0, chain_data=0, chain_load=0, busy=0, done=0, cfg_ready=1, and shift/counter registers are cleared.
REQ-030 nreset asserted mid-transfer SHALL abort immediately with all outputs at reset values; no chain_load and no done pulse SHALL follow.
REQ-031 Outputs SHALL take reset values asynchronously, without needing a clk edge.

Verification
REQ-032 N=8, CW=8, clkdiv=0, cfg_data=64'hA5: 128 SHIFT cycles; bits 63..8 serialize as 0 and bits 7..0 as 1010_0101; then chain_load=1 for 1 cycle, then done for 1 cycle.
REQ-033 clkdiv=3, single transfer: every chain_clk phase is 4 cycles; total 512 SHIFT cycles, then 4 LOAD cycles, then done.
REQ-034 Back-to-back: cfg_valid held high -> second accept occurs in the done cycle; the second transfer starts with zero idle gap.
REQ-035 cfg_valid pulsed during SHIFT with different data -> ignored; the serialized stream matches the first word only.
REQ-036 nreset pulled low at bit 20 -> outputs 0 immediately and cfg_ready=1; after release, a new transfer completes correctly with no residual bits.
REQ-037 clkdiv changed mid-transfer (0->7) -> phase length stays 1 cycle until done.
